// File: rtl/sprite_update_master_if.sv
// Avalon-MM write bus between the sprite update master and the sprite peripheral.
interface sprite_update_master_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       writedata;
    logic              write;
    logic              chipselect;
    logic              waitrequest;

    modport master (
        output address, writedata, write, chipselect,
        input  waitrequest
    );

    modport slave (
        input  address, writedata, write, chipselect,
        output waitrequest
    );
endinterface

// File: rtl/sprite_update_master.sv
// Frame-aligned sprite descriptor flusher: keeps a shadow table with dirty bits
// and, on each frame_start, writes only the changed entries over Avalon-MM.
module sprite_update_master #(
    parameter int N_SPRITES = 3,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_index,
    input  logic [31:0]       upd_data,
    input  logic              frame_start,
    input  logic              status_clr,
    sprite_update_master_if.master bus,
    output logic              busy,
    output logic              overrun,
    output logic              bad_index
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    state_t               state;
    logic [ADDR_W-1:0]    idx;
    logic [31:0]          tbl [N_SPRITES];
    logic [N_SPRITES-1:0] dirty;
    // Entry being written was updated after its snapshot was taken.
    logic                 hit;

    logic [31:0] cur_data;
    logic        cur_dirty;
    logic        upd_ok;
    logic        upd_hit;
    logic        accept;

    // Read-side muxes for the scan pointer and update index range check.
    always_comb begin
        cur_data  = '0;
        cur_dirty = 1'b0;
        upd_ok    = 1'b0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (idx == ADDR_W'(i)) begin
                cur_data  = tbl[i];
                cur_dirty = dirty[i];
            end
            if (upd_index == ADDR_W'(i))
                upd_ok = 1'b1;
        end
        upd_hit = upd_valid && (upd_index == idx);
        accept  = (state == WRITE) && !bus.waitrequest;
    end

    assign busy           = (state != IDLE);
    assign bus.chipselect = bus.write;

    // Flush FSM, shadow table, dirty tracking and sticky status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            hit           <= 1'b0;
            dirty         <= '0;
            bus.address   <= '0;
            bus.writedata <= '0;
            bus.write     <= 1'b0;
            overrun       <= 1'b0;
            bad_index     <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++)
                tbl[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (cur_dirty) begin
                        bus.address   <= idx;
                        bus.writedata <= cur_data;
                        bus.write     <= 1'b1;
                        // An update landing now is newer than the snapshot.
                        hit           <= upd_hit;
                        state         <= WRITE;
                    end else if (idx == LAST) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WRITE: begin
                    hit <= hit | upd_hit;
                    if (accept) begin
                        bus.write <= 1'b0;
                        // Keep dirty if a newer value arrived since the snapshot.
                        for (int i = 0; i < N_SPRITES; i++)
                            if (idx == ADDR_W'(i) && !(hit || upd_hit))
                                dirty[i] <= 1'b0;
                        if (idx == LAST) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Clear first so a same-cycle set event wins.
            if (status_clr) begin
                overrun   <= 1'b0;
                bad_index <= 1'b0;
            end
            if (frame_start && state != IDLE)
                overrun <= 1'b1;

            // Update path, placed last so its dirty set overrides the clear.
            if (upd_valid) begin
                if (upd_ok) begin
                    for (int i = 0; i < N_SPRITES; i++)
                        if (upd_index == ADDR_W'(i)) begin
                            tbl[i]   <= upd_data;
                            dirty[i] <= 1'b1;
                        end
                end else begin
                    bad_index <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_update_master.sv
// Directed bench for sprite_update_master: flush ordering, stalls, re-dirty,
// overrun, bad index and asynchronous reset during a write.
module tb_sprite_update_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic [4:0]  upd_index = '0;
    logic [31:0] upd_data = '0;
    logic        frame_start = 1'b0;
    logic        status_clr = 1'b0;
    logic        busy, overrun, bad_index;

    int n_checks = 0;
    int n_fails  = 0;

    logic [4:0]  log_addr [$];
    logic [31:0] log_data [$];

    sprite_update_master_if #(.ADDR_W(5)) bus ();

    sprite_update_master #(.N_SPRITES(3), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_index(upd_index),
        .upd_data(upd_data), .frame_start(frame_start), .status_clr(status_clr),
        .bus(bus), .busy(busy), .overrun(overrun), .bad_index(bad_index)
    );

    always #10 clk = ~clk;

    // Record every accepted Avalon write.
    always @(posedge clk) begin
        if (!reset && bus.write && !bus.waitrequest) begin
            log_addr.push_back(bus.address);
            log_data.push_back(bus.writedata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [4:0] i, input logic [31:0] d);
        upd_valid = 1'b1; upd_index = i; upd_data = d;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin tick(); k++; end
        chk("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_idle();
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        bus.waitrequest = 1'b0;
        tick(); tick();

        // Reset values while reset is held.
        chk("rst_address",   {27'b0, bus.address}, 32'd0);
        chk("rst_writedata", bus.writedata, 32'd0);
        chk("rst_write",     {31'b0, bus.write}, 32'd0);
        chk("rst_cs",        {31'b0, bus.chipselect}, 32'd0);
        chk("rst_busy",      {31'b0, busy}, 32'd0);
        chk("rst_flags",     {30'b0, overrun, bad_index}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic flush of entries 0 and 2, no stalls.
        upd(5'd0, 32'h0010_1407);
        upd(5'd2, 32'h0020_7C10);
        clear_log();
        frame_start = 1'b1;
        tick();                                  // t+1
        frame_start = 1'b0;
        chk("t1_busy",  {31'b0, busy}, 32'd1);
        chk("t1_write", {31'b0, bus.write}, 32'd0);
        tick();                                  // t+2
        chk("t2_write", {31'b0, bus.write}, 32'd1);
        chk("t2_cs",    {31'b0, bus.chipselect}, 32'd1);
        chk("t2_addr",  {27'b0, bus.address}, 32'd0);
        chk("t2_data",  bus.writedata, 32'h0010_1407);
        tick(); tick(); tick();                  // t+5
        chk("t5_addr",  {27'b0, bus.address}, 32'd2);
        chk("t5_write", {31'b0, bus.write}, 32'd1);
        tick();                                  // t+6
        chk("t6_busy",  {31'b0, busy}, 32'd0);
        chk("f1_count", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            chk("f1_addr0", {27'b0, log_addr[0]}, 32'd0);
            chk("f1_data0", log_data[0], 32'h0010_1407);
            chk("f1_addr1", {27'b0, log_addr[1]}, 32'd2);
            chk("f1_data1", log_data[1], 32'h0020_7C10);
        end
        clear_log();
        run_frame();
        chk("clean_count", log_addr.size(), 32'd0);

        // Three stall cycles on the first write.
        upd(5'd0, 32'hFE0A_BCDE);
        clear_log();
        bus.waitrequest = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();                                  // first write cycle
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.waitrequest = 1'b0;
            chk("stall_write", {31'b0, bus.write}, 32'd1);
            chk("stall_addr",  {27'b0, bus.address}, 32'd0);
            chk("stall_data",  bus.writedata, 32'hFE0A_BCDE);
            if (c < 3) tick();
        end
        wait_idle();
        chk("stall_count", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) chk("stall_logdata", log_data[0], 32'hFE0A_BCDE);

        // Update entry 1 while its write is stalled.
        upd(5'd1, 32'h0030_0C03);
        clear_log();
        bus.waitrequest = 1'b1;
        frame_start = 1'b1;
        tick();                                  // SCAN 0
        frame_start = 1'b0;
        tick();                                  // SCAN 1
        tick();                                  // WRITE 1
        chk("re_addr", {27'b0, bus.address}, 32'd1);
        upd(5'd1, 32'h0031_0404);
        chk("re_data_held", bus.writedata, 32'h0030_0C03);
        bus.waitrequest = 1'b0;
        wait_idle();
        chk("re_count", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) chk("re_old", log_data[0], 32'h0030_0C03);
        clear_log();
        run_frame();
        chk("re_next_count", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            chk("re_next_addr", {27'b0, log_addr[0]}, 32'd1);
            chk("re_next_data", log_data[0], 32'h0031_0404);
        end

        // frame_start while busy: overrun, sequence unchanged.
        upd(5'd0, 32'h0000_0001);
        upd(5'd2, 32'h0000_0002);
        clear_log();
        frame_start = 1'b1;
        tick();
        tick();                                  // second pulse sampled while busy
        frame_start = 1'b0;
        chk("ovr_set", {31'b0, overrun}, 32'd1);
        wait_idle();
        chk("ovr_count", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            chk("ovr_addr0", {27'b0, log_addr[0]}, 32'd0);
            chk("ovr_addr1", {27'b0, log_addr[1]}, 32'd2);
        end
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("ovr_clr", {31'b0, overrun}, 32'd0);

        // Out-of-range update is dropped and flagged.
        upd(5'd7, 32'hDEAD_BEEF);
        chk("bad_set", {31'b0, bad_index}, 32'd1);
        clear_log();
        run_frame();
        chk("bad_count", log_addr.size(), 32'd0);
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        chk("bad_clr", {31'b0, bad_index}, 32'd0);

        // Asynchronous reset during a stalled write.
        upd(5'd0, 32'h0012_3456);
        bus.waitrequest = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("ar_pre_write", {31'b0, bus.write}, 32'd1);
        reset = 1'b1;
        #2;
        chk("ar_write", {31'b0, bus.write}, 32'd0);
        chk("ar_cs",    {31'b0, bus.chipselect}, 32'd0);
        chk("ar_busy",  {31'b0, busy}, 32'd0);
        chk("ar_addr",  {27'b0, bus.address}, 32'd0);
        chk("ar_data",  bus.writedata, 32'd0);
        tick();
        reset = 1'b0;
        bus.waitrequest = 1'b0;
        tick();
        clear_log();
        run_frame();
        chk("ar_count", log_addr.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/sprite_update_master.md
# sprite_update_master

Avalon-MM write master that drives the sprite-descriptor register port of the VGA sprite peripheral from the initiator side. It holds a local shadow table of sprite descriptors, tracks which entries changed, and on each frame-start pulse flushes only the dirty entries to the peripheral with `write`/`chipselect`/`waitrequest` handshaking. This keeps descriptor updates frame-aligned and off the CPU bus.

## Interface
- `N_SPRITES`, default 3: number of descriptor entries, range 1..20; entry i is written to peripheral address i.
- `ADDR_W`, default 5: width of the entry index and of the Avalon address.
- `clk` in 1: system clock, 50 MHz domain shared with the peripheral.
- `reset` in 1: asynchronous, active-high.
- `upd_valid` in 1: a descriptor update is presented this cycle.
- `upd_index` in ADDR_W: target entry of the update.
- `upd_data` in 32: descriptor with id in [24:20], x in [19:10], y in [9:0], and [31:25] passed through unchanged.
- `frame_start` in 1: single-cycle pulse, the vblank start.
- `status_clr` in 1: clears the sticky status flags.
- `address` out ADDR_W: Avalon address.
- `writedata` out 32: Avalon write data.
- `write` out 1: Avalon write strobe.
- `chipselect` out 1: equal to `write`.
- `waitrequest` in 1: slave stall; a write is accepted in any cycle with `write`=1 and `waitrequest`=0.
- `busy` out 1: a flush is in progress, meaning state is not IDLE.
- `overrun` out 1: sticky; set when `frame_start` arrives while `busy`.
- `bad_index` out 1: sticky; set when an update is presented with `upd_index` >= N_SPRITES.

## Operation
- Storage:
  - `table[N_SPRITES]` × 32 bits.
  - `dirty[N_SPRITES]`.
  - Scan pointer `idx`.
  - Registered `address`, `writedata`, `write`.
- Update path:
  - Always accepted; there is no ready signal.
  - Valid index: `table[upd_index]` <= `upd_data` and `dirty[upd_index]` <= 1.
  - Index >= N_SPRITES: the update is dropped, `bad_index` is set, and the table is unchanged.
- States are IDLE, SCAN and WRITE.
  - IDLE: `frame_start` -> SCAN with `idx`=0. Otherwise stay.
  - SCAN: test `dirty[idx]`.
    - Dirty: latch `address`<=`idx` and `writedata`<=`table[idx]`, then go to WRITE with `write`=1.
    - Clean and `idx`=N_SPRITES-1: go to IDLE.
    - Clean otherwise: `idx`++ and stay in SCAN.
  - WRITE: hold `address`, `writedata` and `write` stable while `waitrequest`=1.
    - On acceptance: `write`<=0 and clear `dirty[idx]`.
    - Then `idx`=N_SPRITES-1 -> IDLE, else `idx`++ -> SCAN.
- Dirty-clear precedence: if a valid update targets the same entry in the acceptance cycle, or at any time after its snapshot was latched, `dirty` stays or becomes 1. The value already latched is still sent, and the new value goes out on the next frame.
- `frame_start` while not IDLE is ignored for sequencing and sets `overrun`. The flush in progress continues unchanged.
- `status_clr` clears `overrun` and `bad_index`. If a set event occurs in the same cycle, set wins.
- `idx` never exceeds N_SPRITES-1 and has no wrap-around past the last entry.

## Timing
- Reset values:
  - `address`=0, `writedata`=0, `write`=0, `chipselect`=0, `busy`=0, `overrun`=0, `bad_index`=0.
  - Table all zero, dirty all zero, state IDLE, `idx`=0.
- Reset asserted mid-write deasserts `write` immediately (asynchronous); the pending entry is lost.
- `frame_start` in cycle t gives SCAN for entry 0 in t+1. If entry 0 is dirty, `write`=1 in t+2.
- Per entry:
  - Clean entry: 1 cycle.
  - Dirty entry: 1 SCAN cycle + (1 + waitrequest stall cycles) WRITE cycles.
- Worst-case flush with no stalls: 2·N_SPRITES cycles.
- `busy` falls the cycle after the last entry is resolved.
- Update to the table is visible to SCAN one cycle later (registered).

## Test plan
- Reset, then updates to 0 (0x0010_0000+…) and 2, then `frame_start` with `waitrequest`=0 -> exactly two writes, address 0 then address 2, with matching data. `write` is first high at t+2. `busy` is low by t+6 and dirty is cleared.
- `waitrequest` held high 3 cycles on the first write -> `address`/`writedata`/`write` stable for 4 cycles, and exactly one acceptance.
- Update entry 1 during its own WRITE stall -> the old value is written this frame; the next `frame_start` writes the new value to address 1.
- `frame_start` while `busy` -> `overrun`=1 and the flush sequence is unchanged. `status_clr` -> `overrun`=0.
- Update with `upd_index`=7 (N_SPRITES=3) -> `bad_index`=1, and the next frame issues no writes.
- Reset asserted while `write`=1 -> `write`=0 asynchronously, everything is at reset values, and the following `frame_start` issues no writes.
